// File: rtl/keypad_emulator.sv
// keypad_emulator
//   Emulates a single key press on a 4x4 scanned keypad matrix. Requested keys
//   are queued, then "pressed" one at a time: while a key is held, the row
//   return lines echo the key's row bit whenever the scanner drives that key's
//   column strobe. After HOLD_SCANS matching strobes the key is released for
//   GAP_CYCLES cycles before the next queued key is pressed.
//
//   Build option: define KEYEMU_FIFO_EN to compile in a 4-entry request FIFO
//   (key_ready = !full). Without it a single holding register is used and a
//   request is only accepted while idle with the register empty.
//
// Parameters
//   HOLD_SCANS : matching strobe cycles per press (1-15)
//   GAP_CYCLES : released cycles after each press (4-255)
// Ports
//   clk       : clock, rising edge
//   rst_n     : synchronous active-low reset
//   key_valid : key request valid
//   key_code  : key number 0-15, stable while key_valid && !key_ready
//   key_ready : request accepted on an edge where key_valid && key_ready
//   scan_in   : column strobe from the matrix scanner
//   ret_out   : emulated row return lines
//   busy      : a key is being pressed/released or a request is waiting
//   cur_key   : key currently pressed, 16 when none
module keypad_emulator #(
    parameter int HOLD_SCANS = 2,
    parameter int GAP_CYCLES = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       key_valid,
    input  logic [3:0] key_code,
    output logic       key_ready,
    input  logic [3:0] scan_in,
    output logic [3:0] ret_out,
    output logic       busy,
    output logic [4:0] cur_key
);

    typedef enum logic [1:0] {
        IDLE,
        PRESS,
        GAP
    } state_t;

    localparam logic [3:0] HOLD_TARGET = 4'(HOLD_SCANS);
    localparam logic [7:0] GAP_LAST    = 8'(GAP_CYCLES - 1);
    localparam logic [4:0] NO_KEY      = 5'd16;

    state_t     state;
    logic [3:0] active_key;
    logic [3:0] hit_cnt;
    logic [7:0] gap_cnt;

    logic       pending;
    logic [3:0] head_key;
    logic       push;
    logic       pop;
    logic       strobe_hit;
    logic       gap_done;

    // A strobe only matches when it equals the key's one-hot column code, so
    // zero and multi-hot strobes can never register as a hit.
    assign strobe_hit = (state == PRESS) && (scan_in == (4'b1000 >> active_key[3:2]));
    assign ret_out    = strobe_hit ? (4'b0001 << active_key[1:0]) : 4'b0000;

    assign gap_done   = (state == GAP) && (gap_cnt == GAP_LAST);
    assign pop        = pending && ((state == IDLE) || gap_done);
    assign push       = key_valid && key_ready;
    assign busy       = (state != IDLE) || pending;

`ifdef KEYEMU_FIFO_EN
    logic [3:0] fifo_mem [4];
    logic [1:0] wr_ptr;
    logic [1:0] rd_ptr;
    logic [2:0] fifo_count;

    assign key_ready = (fifo_count != 3'd4);
    assign pending   = (fifo_count != 3'd0);
    assign head_key  = fifo_mem[rd_ptr];

    // Request FIFO; a push and a pop on the same edge leave the count unchanged.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr     <= 2'd0;
            rd_ptr     <= 2'd0;
            fifo_count <= 3'd0;
        end else begin
            if (push) begin
                fifo_mem[wr_ptr] <= key_code;
                wr_ptr           <= wr_ptr + 2'd1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 2'd1;
            end
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + 3'd1;
                2'b01:   fifo_count <= fifo_count - 3'd1;
                default: fifo_count <= fifo_count;
            endcase
        end
    end
`else
    logic [3:0] hold_key;
    logic       hold_valid;

    assign key_ready = (state == IDLE) && !hold_valid;
    assign pending   = hold_valid;
    assign head_key  = hold_key;

    // Single holding register; it is only loaded while idle and is popped on
    // the very next edge, so push and pop never coincide.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hold_key   <= 4'd0;
            hold_valid <= 1'b0;
        end else if (push) begin
            hold_key   <= key_code;
            hold_valid <= 1'b1;
        end else if (pop) begin
            hold_valid <= 1'b0;
        end
    end
`endif

    // Press sequencer. Counters are cleared on every state entry; cur_key is
    // registered alongside the state so it changes on the same edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            active_key <= 4'd0;
            hit_cnt    <= 4'd0;
            gap_cnt    <= 8'd0;
            cur_key    <= NO_KEY;
        end else begin
            case (state)
                IDLE: begin
                    if (pop) begin
                        state      <= PRESS;
                        active_key <= head_key;
                        cur_key    <= {1'b0, head_key};
                        hit_cnt    <= 4'd0;
                        gap_cnt    <= 8'd0;
                    end
                end
                PRESS: begin
                    if (strobe_hit) begin
                        if ((hit_cnt + 4'd1) == HOLD_TARGET) begin
                            state   <= GAP;
                            cur_key <= NO_KEY;
                            hit_cnt <= 4'd0;
                            gap_cnt <= 8'd0;
                        end else begin
                            hit_cnt <= hit_cnt + 4'd1;
                        end
                    end
                end
                GAP: begin
                    if (gap_done) begin
                        hit_cnt <= 4'd0;
                        gap_cnt <= 8'd0;
                        if (pop) begin
                            state      <= PRESS;
                            active_key <= head_key;
                            cur_key    <= {1'b0, head_key};
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        gap_cnt <= gap_cnt + 8'd1;
                    end
                end
                default: begin
                    state   <= IDLE;
                    cur_key <= NO_KEY;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_keypad_emulator.sv
// tb_keypad_emulator
//   Self-checking bench for keypad_emulator (default parameters). A fixed
//   vector table covers reset and two complete presses, hand-written
//   sequences cover invalid strobes, queueing order and a mid-press reset,
//   and a randomized phase is compared cycle by cycle against a queue-based
//   reference model. Works for both builds (KEYEMU_FIFO_EN defined or not).
module tb_keypad_emulator;

    localparam int HOLD = 2;
    localparam int GAP  = 8;
`ifdef KEYEMU_FIFO_EN
    localparam bit IS_FIFO = 1'b1;
`else
    localparam bit IS_FIFO = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic       key_valid;
    logic [3:0] key_code;
    logic       key_ready;
    logic [3:0] scan_in;
    logic [3:0] ret_out;
    logic       busy;
    logic [4:0] cur_key;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    keypad_emulator #(
        .HOLD_SCANS(HOLD),
        .GAP_CYCLES(GAP)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .key_valid(key_valid),
        .key_code (key_code),
        .key_ready(key_ready),
        .scan_in  (scan_in),
        .ret_out  (ret_out),
        .busy     (busy),
        .cur_key  (cur_key)
    );

    // Reference model: the key being held (-1 when none), how many matching
    // strobes it still needs, how many released cycles remain, and the
    // accepted-but-not-yet-pressed keys in order.
    int m_active    = -1;
    int m_hits_left = 0;
    int m_gap_left  = 0;
    int m_queue[$];
    bit m_known     = 1'b0;

    function automatic logic [3:0] modelRet(input logic [3:0] scan);
        if (m_active < 0) return 4'b0000;
        if (int'(scan) != (8 >> (m_active / 4))) return 4'b0000;
        return 4'(1 << (m_active % 4));
    endfunction

    function automatic bit modelIdle();
        return (m_active < 0) && (m_gap_left == 0);
    endfunction

    function automatic bit modelReady();
        if (IS_FIFO) return m_queue.size() < 4;
        return modelIdle() && (m_queue.size() == 0);
    endfunction

    function automatic bit modelBusy();
        return !modelIdle() || (m_queue.size() > 0);
    endfunction

    function automatic int modelCur();
        return (m_active < 0) ? 16 : m_active;
    endfunction

    // Advance the model across one rising edge with the inputs that were applied.
    task automatic modelStep(input logic r, input logic v, input logic [3:0] code,
                             input logic [3:0] scan);
        bit acc;
        if (!r) begin
            m_active    = -1;
            m_hits_left = 0;
            m_gap_left  = 0;
            m_queue.delete();
            m_known     = 1'b1;
            return;
        end
        if (!m_known) return;
        acc = v && modelReady();
        if (m_active >= 0) begin
            if (modelRet(scan) != 4'b0000) begin
                m_hits_left--;
                if (m_hits_left == 0) begin
                    m_active   = -1;
                    m_gap_left = GAP;
                end
            end
        end else if (m_gap_left > 0) begin
            m_gap_left--;
            if (m_gap_left == 0 && m_queue.size() > 0) begin
                m_active    = m_queue.pop_front();
                m_hits_left = HOLD;
            end
        end else if (m_queue.size() > 0) begin
            m_active    = m_queue.pop_front();
            m_hits_left = HOLD;
        end
        if (acc) m_queue.push_back(int'(code));
    endtask

    task automatic checkOutput(input string name, input logic [7:0] actual,
                               input logic [7:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d at t=%0t", name, actual, expected, $time);
        end
    endtask

    task automatic driveInputs(input logic r, input logic v, input logic [3:0] code,
                               input logic [3:0] scan);
        rst_n     = r;
        key_valid = v;
        key_code  = code;
        scan_in   = scan;
        #1;
    endtask

    task automatic modelCheck(input string tag);
        if (m_known) begin
            checkOutput({tag, ".ret"},   {4'b0, ret_out},   8'(modelRet(scan_in)));
            checkOutput({tag, ".cur"},   {3'b0, cur_key},   8'(modelCur()));
            checkOutput({tag, ".busy"},  {7'b0, busy},      8'(modelBusy()));
            checkOutput({tag, ".ready"}, {7'b0, key_ready}, 8'(modelReady()));
        end
    endtask

    task automatic advance();
        @(posedge clk);
        modelStep(rst_n, key_valid, key_code, scan_in);
        @(negedge clk);
    endtask

    task automatic applyStimulus(input logic r, input logic v, input logic [3:0] code,
                                 input logic [3:0] scan, input string tag);
        driveInputs(r, v, code, scan);
        modelCheck(tag);
        advance();
    endtask

    task automatic stepExpect(input logic [3:0] scan, input logic [3:0] eret,
                              input logic [4:0] ecur, input string tag);
        driveInputs(1'b1, 1'b0, 4'd0, scan);
        modelCheck(tag);
        checkOutput({tag, ".ret_exp"}, {4'b0, ret_out}, {4'b0, eret});
        checkOutput({tag, ".cur_exp"}, {3'b0, cur_key}, {3'b0, ecur});
        advance();
    endtask

    typedef struct {
        logic       r;
        logic       v;
        logic [3:0] code;
        logic [3:0] scan;
        bit         chk;
        logic [3:0] ret;
        logic [4:0] cur;
        logic       busy;
        logic       ready;
    } vec_t;

    function automatic vec_t mk(input logic r, input logic v, input logic [3:0] code,
                                input logic [3:0] scan, input bit chk, input logic [3:0] ret,
                                input logic [4:0] cur, input logic b, input logic rdy);
        vec_t x;
        x.r = r; x.v = v; x.code = code; x.scan = scan; x.chk = chk;
        x.ret = ret; x.cur = cur; x.busy = b; x.ready = rdy;
        return x;
    endfunction

    initial begin
        vec_t vecs[$];
        logic nr;
        int   seen[$];
        int   expect_order[6];
        int   next_key;
        int   cyc;
        int   bad_cur;
        bit   adv;
        logic r, v, hold_v, rdy;
        logic [3:0] c, s, hold_c;

        nr = IS_FIFO;
        rst_n = 1'b0; key_valid = 1'b0; key_code = 4'd0; scan_in = 4'd0;

        // Reset, key 6 with rotating strobes, then key 15 with a held strobe.
        vecs.push_back(mk(0, 0, 0,  4'b0000, 0, 0,       0,  0, 0));
        vecs.push_back(mk(0, 1, 3,  4'b0000, 1, 4'b0000, 16, 0, 1));
        vecs.push_back(mk(1, 1, 6,  4'b1000, 1, 4'b0000, 16, 0, 1));
        vecs.push_back(mk(1, 0, 0,  4'b0100, 1, 4'b0000, 16, 1, nr));
        vecs.push_back(mk(1, 0, 0,  4'b1000, 1, 4'b0000, 6,  1, nr));
        vecs.push_back(mk(1, 0, 0,  4'b0100, 1, 4'b0100, 6,  1, nr));
        vecs.push_back(mk(1, 0, 0,  4'b0010, 1, 4'b0000, 6,  1, nr));
        vecs.push_back(mk(1, 0, 0,  4'b0001, 1, 4'b0000, 6,  1, nr));
        vecs.push_back(mk(1, 0, 0,  4'b1000, 1, 4'b0000, 6,  1, nr));
        vecs.push_back(mk(1, 0, 0,  4'b0100, 1, 4'b0100, 6,  1, nr));
        for (int i = 0; i < GAP; i++)
            vecs.push_back(mk(1, 0, 0, 4'b0100, 1, 4'b0000, 16, 1, nr));
        vecs.push_back(mk(1, 1, 15, 4'b0001, 1, 4'b0000, 16, 0, 1));
        vecs.push_back(mk(1, 0, 0,  4'b0001, 1, 4'b0000, 16, 1, nr));
        vecs.push_back(mk(1, 0, 0,  4'b0001, 1, 4'b1000, 15, 1, nr));
        vecs.push_back(mk(1, 0, 0,  4'b0001, 1, 4'b1000, 15, 1, nr));
        vecs.push_back(mk(1, 0, 0,  4'b0001, 1, 4'b0000, 16, 1, nr));

        @(negedge clk);
        for (int i = 0; i < vecs.size(); i++) begin
            driveInputs(vecs[i].r, vecs[i].v, vecs[i].code, vecs[i].scan);
            modelCheck($sformatf("vec%0d", i));
            if (vecs[i].chk) begin
                checkOutput($sformatf("vec%0d.ret", i),   {4'b0, ret_out},   {4'b0, vecs[i].ret});
                checkOutput($sformatf("vec%0d.cur", i),   {3'b0, cur_key},   {3'b0, vecs[i].cur});
                checkOutput($sformatf("vec%0d.busy", i),  {7'b0, busy},      {7'b0, vecs[i].busy});
                checkOutput($sformatf("vec%0d.ready", i), {7'b0, key_ready}, {7'b0, vecs[i].ready});
            end
            advance();
        end
        for (int i = 0; i < 10; i++) applyStimulus(1, 0, 0, 4'b0000, "drain1");

        // Key 0 with zero and multi-hot strobes mixed in.
        applyStimulus(1, 1, 0, 4'b0000, "inv_accept");
        applyStimulus(1, 0, 0, 4'b0000, "inv_pending");
        stepExpect(4'b1100, 4'b0000, 5'd0,  "inv_1100");
        stepExpect(4'b0000, 4'b0000, 5'd0,  "inv_0000");
        stepExpect(4'b1000, 4'b0001, 5'd0,  "inv_hit1");
        stepExpect(4'b1110, 4'b0000, 5'd0,  "inv_1110");
        stepExpect(4'b0000, 4'b0000, 5'd0,  "inv_0000b");
        stepExpect(4'b1000, 4'b0001, 5'd0,  "inv_hit2");
        stepExpect(4'b1000, 4'b0000, 5'd16, "inv_gap");
        for (int i = 0; i < 10; i++) applyStimulus(1, 0, 0, 4'b0000, "drain2");

        // Key 0 then keys 1-5 offered back-to-back; presses must follow that order.
        applyStimulus(1, 1, 0, 4'b0000, "q_accept0");
        applyStimulus(1, 0, 0, 4'b0000, "q_pending0");
        next_key = 1;
        cyc = 0;
        while ((next_key <= 5 || modelBusy()) && cyc < 300) begin
            s = 4'(8 >> (cyc % 4));
            driveInputs(1, next_key <= 5, 4'(next_key <= 5 ? next_key : 0), s);
            if (cur_key != 5'd16 && (seen.size() == 0 || seen[$] != int'(cur_key)))
                seen.push_back(int'(cur_key));
`ifdef KEYEMU_FIFO_EN
            if (cyc == 4) checkOutput("fifo_full_stall", {7'b0, key_ready}, 8'd0);
`else
            if (cyc == 0) checkOutput("hold_press_ready", {7'b0, key_ready}, 8'd0);
`endif
            adv = (next_key <= 5) && modelReady();
            modelCheck("queue");
            advance();
            if (adv) next_key++;
            cyc++;
        end
        checkOutput("queue_timeout", 8'(cyc < 300), 8'd1);
        checkOutput("queue_press_count", 8'(seen.size()), 8'd6);
        expect_order = '{0, 1, 2, 3, 4, 5};
        for (int i = 0; i < 6; i++)
            checkOutput($sformatf("queue_order%0d", i),
                        8'(i < seen.size() ? seen[i] : 99), 8'(expect_order[i]));
        for (int i = 0; i < 4; i++) applyStimulus(1, 0, 0, 4'b0000, "drain3");

        // Reset pulse while key 9 is held and further keys are waiting.
        applyStimulus(1, 1, 9, 4'b0000, "rst_accept9");
        applyStimulus(1, 0, 0, 4'b0000, "rst_pending");
        applyStimulus(1, 1, 3, 4'b0000, "rst_offer3");
        applyStimulus(1, 0, 0, 4'b0000, "rst_idle");
        applyStimulus(1, 1, 4, 4'b0000, "rst_offer4");
        applyStimulus(1, 0, 0, 4'b0000, "rst_idle2");
        applyStimulus(0, 1, 5, 4'b0010, "rst_pulse");
        driveInputs(1, 0, 0, 4'b0010);
        checkOutput("rst_mid.ret",   {4'b0, ret_out},   8'd0);
        checkOutput("rst_mid.cur",   {3'b0, cur_key},   8'd16);
        checkOutput("rst_mid.busy",  {7'b0, busy},      8'd0);
        checkOutput("rst_mid.ready", {7'b0, key_ready}, 8'd1);
        modelCheck("rst_after");
        advance();
        bad_cur = 0;
        for (int i = 0; i < 20; i++) begin
            driveInputs(1, 0, 0, 4'(8 >> (i % 4)));
            if (cur_key != 5'd16 || ret_out != 4'b0000) bad_cur++;
            modelCheck("rst_quiet");
            advance();
        end
        checkOutput("rst_no_queued_press", 8'(bad_cur), 8'd0);

        // Randomized traffic against the model, with occasional resets.
        hold_v = 1'b0;
        hold_c = 4'd0;
        for (int i = 0; i < 1500; i++) begin
            r = ($urandom_range(0, 199) != 0);
            if (hold_v) begin
                v = 1'b1;
                c = hold_c;
            end else begin
                v = ($urandom_range(0, 2) == 0);
                c = 4'($urandom_range(0, 15));
            end
            if ($urandom_range(0, 3) == 0) s = 4'($urandom_range(0, 15));
            else                           s = 4'(1 << $urandom_range(0, 3));
            rdy = modelReady();
            applyStimulus(r, v, c, s, "rand");
            hold_v = v && !rdy && r;
            hold_c = c;
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
